// File: rtl/gpu_cmd_arbiter_pkg.sv
// Shared constants and state encodings for the command arbiter and the vertex-processing path.
package gpu_cmd_arbiter_pkg;

  // Packet terminator word, also recognised downstream in the vertex-processing path.
  localparam logic [31:0] GL_END = 32'h0000_00FF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping upward.
module gpu_rr_picker #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = (32'(ptr) + off) % NUM_SRC;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gpu_cmd_arbiter.sv
// Packet-granular round-robin arbiter feeding the vertex-processing FIFO through a one-word
// output register; a granted source owns the output until its GL_END word.
module gpu_cmd_arbiter
  import gpu_cmd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 32,
  parameter bit          FWD_END = 1'b0,
  localparam int unsigned GNT_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      pll_clock,
  input  logic                      sys_reset,
  input  logic                      arb_enable,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      vert_processing_fifo_in_valid,
  output logic [DATA_W-1:0]         vert_processing_fifo_in_data,
  input  logic                      vert_processing_fifo_in_ready,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      pkt_done
);

  localparam logic [DATA_W-1:0] END_WORD = DATA_W'(GL_END);

  arb_state_e        state_q, state_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [GNT_W-1:0]  rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              pkt_done_q, pkt_done_d;

  logic              slot_free;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              in_xfer;
  logic              load;
  logic              any_req;
  logic [GNT_W-1:0]  winner;

  gpu_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (GNT_W)
  ) u_picker (
    .req     (src_valid),
    .ptr     (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GNT_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy      = (state_q == ARB_CMD) || (state_q == ARB_DATA);
  assign slot_free = !out_valid_q || vert_processing_fifo_in_ready;
  assign in_xfer   = busy && slot_free && sel_valid;

  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = busy && slot_free && (grant_q == GNT_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    pkt_done_d = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_enable && any_req) begin
          grant_d = winner;
          state_d = ARB_CMD;
        end
      end
      ARB_CMD: begin
        // The command word is never treated as a terminator, even if it equals GL_END.
        if (in_xfer) begin
          load    = 1'b1;
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (in_xfer) begin
          if (sel_data == END_WORD) begin
            load       = FWD_END;
            pkt_done_d = 1'b1;
            rr_d       = (grant_q == GNT_W'(NUM_SRC - 1)) ? '0 : grant_q + GNT_W'(1);
            state_d    = ARB_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge pll_clock) begin
    if (sys_reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign vert_processing_fifo_in_valid = out_valid_q;
  assign vert_processing_fifo_in_data  = out_data_q;
  assign grant_id                      = grant_q;
  assign pkt_done                      = pkt_done_q;

endmodule

// File: tb/tb_gpu_cmd_arbiter.sv
// Scoreboard bench: a packet-level round-robin model predicts the output word stream and the
// source finishing each packet; a negedge monitor checks the DUT against those queues.
module tb_gpu_cmd_arbiter;
  import gpu_cmd_arbiter_pkg::*;

  localparam int unsigned NS  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned GW  = 2;
  localparam bit          FWD = 1'b0;
  localparam logic [DW-1:0] END_W = GL_END;

  logic             pll_clock;
  logic             sys_reset;
  logic             arb_enable;
  logic [NS-1:0]    src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             pkt_done;

  gpu_cmd_arbiter #(
    .NUM_SRC (NS),
    .DATA_W  (DW),
    .FWD_END (FWD)
  ) dut (
    .pll_clock                     (pll_clock),
    .sys_reset                     (sys_reset),
    .arb_enable                    (arb_enable),
    .src_valid                     (src_valid),
    .src_data                      (src_data),
    .src_ready                     (src_ready),
    .vert_processing_fifo_in_valid (out_valid),
    .vert_processing_fifo_in_data  (out_data),
    .vert_processing_fifo_in_ready (out_ready),
    .grant_id                      (grant_id),
    .busy                          (busy),
    .pkt_done                      (pkt_done)
  );

  initial pll_clock = 1'b0;
  always #5 pll_clock = ~pll_clock;

  int n_chk  = 0;
  int n_pass = 0;
  int pkt_cnt = 0;
  int mptr = 0;

  logic [DW-1:0] wq [NS][$];
  bit            lq [NS][$];
  bit            first_w [NS];
  logic [DW-1:0] pk [$];
  logic [DW-1:0] exp_d [$];
  int            exp_g [$];

  bit mon_en = 1'b0;
  bit rand_ready = 1'b0, rand_en = 1'b0, bubbles = 1'b0;
  bit ready_val = 1'b1, en_val = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: output words, packet completions and handshake rules.
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  initial begin
    forever begin
      @(negedge pll_clock);
      if (mon_en) begin
        if (hold_pend) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(hold_data));
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && !out_ready) chk("ready_under_bp", 64'(src_ready), 64'd0);
        if (!busy) chk("ready_idle", 64'(src_ready), 64'd0);
        chk("ready_grant_only", 64'(src_ready & ~(NS'(1) << grant_id)), 64'd0);
        if (out_valid && out_ready) begin
          if (exp_d.size() == 0) fail_now("extra_word");
          else chk("out_data", 64'(out_data), 64'(exp_d.pop_front()));
        end
        if (pkt_done) begin
          pkt_cnt++;
          if (exp_g.size() == 0) fail_now("extra_pkt_done");
          else chk("pkt_grant", 64'(grant_id), 64'(exp_g.pop_front()));
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = END_W;
    while (w == END_W) w = $urandom;
    return w;
  endfunction

  task automatic push_pkt(input int s);
    for (int k = 0; k < pk.size(); k++) begin
      wq[s].push_back(pk[k]);
      lq[s].push_back(k == pk.size() - 1);
    end
  endtask

  task automatic rand_pkt(input int s);
    int nd;
    nd = $urandom_range(0, 4);
    pk.delete();
    if ($urandom_range(0, 7) == 0) pk.push_back(END_W);
    else pk.push_back(rand_word());
    repeat (nd) pk.push_back(rand_word());
    pk.push_back(END_W);
    push_pkt(s);
  endtask

  // Packet-level model over everything queued and not yet consumed.
  task automatic model_phase();
    int pos [NS];
    int w;
    int s;
    bit last;
    for (int i = 0; i < NS; i++) pos[i] = 0;
    while (1) begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        s = (mptr + k) % NS;
        if (w < 0 && pos[s] < wq[s].size()) w = s;
      end
      if (w < 0) break;
      exp_g.push_back(w);
      while (1) begin
        last = lq[w][pos[w]];
        if (!last || FWD) exp_d.push_back(wq[w][pos[w]]);
        pos[w]++;
        if (last) break;
      end
      mptr = (w + 1) % NS;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (wq[i].size() != 0) begin
        src_valid[i] = first_w[i] || !bubbles || ($urandom_range(0, 3) != 0);
        src_data[i*DW +: DW] = wq[i][0];
      end else begin
        src_valid[i] = 1'b0;
        src_data[i*DW +: DW] = '0;
      end
    end
    out_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
    arb_enable = rand_en ? ($urandom_range(0, 7) != 0) : en_val;
  endtask

  task automatic step();
    bit xf [NS];
    @(negedge pll_clock);
    for (int i = 0; i < NS; i++) xf[i] = src_valid[i] && src_ready[i];
    @(posedge pll_clock);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (xf[i] && wq[i].size() != 0) begin
        first_w[i] = lq[i][0];
        void'(wq[i].pop_front());
        void'(lq[i].pop_front());
      end
    end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NS; i++) if (wq[i].size() != 0) return 1'b1;
    return exp_d.size() != 0 || exp_g.size() != 0;
  endfunction

  task automatic run_phase(input string name, input int budget);
    int n;
    n = 0;
    drive();
    while (pending() && n < budget) begin
      step();
      n++;
    end
    if (pending()) fail_now(name);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) begin
      wq[i].delete();
      lq[i].delete();
      first_w[i] = 1'b1;
    end
    exp_d.delete();
    exp_g.delete();
  endtask

  initial begin
    int n;
    int pc0;
    logic [DW-1:0] held;

    clear_all();
    sys_reset = 1'b1;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b1;
    arb_enable = 1'b1;
    repeat (2) @(posedge pll_clock);
    #1;
    sys_reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    mon_en = 1'b1;

    // Contention from reset: 0,1 then 0 again, including a GL_END command word.
    pk = '{32'hA1, 32'hA2, END_W};        push_pkt(0);
    pk = '{32'hB1, 32'hB2, END_W};        push_pkt(1);
    pk = '{32'hC1, 32'hC2, END_W};        push_pkt(0);
    pk = '{END_W, 32'h33, END_W};         push_pkt(1);
    model_phase();
    run_phase("contention_timeout", 200);

    // Single packet, GL_END dropped, one completion.
    pc0 = pkt_cnt;
    pk = '{32'h0004, 32'h11, 32'h22, END_W};
    push_pkt(0);
    model_phase();
    run_phase("single_pkt_timeout", 100);
    chk("single_pkt_done_count", 64'(pkt_cnt - pc0), 64'd1);

    // Back-pressure held for 5 cycles mid-packet.
    pk = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55, END_W};
    push_pkt(0);
    model_phase();
    drive();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) fail_now("bp_no_output");
    ready_val = 1'b0;
    out_ready = 1'b0;
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data_stable", 64'(out_data), 64'(held));
      chk("bp_src_ready", 64'(src_ready), 64'd0);
    end
    ready_val = 1'b1;
    run_phase("bp_timeout", 100);

    // arb_enable dropped mid-packet: packet completes, then no new grant.
    pk = '{32'h60, 32'h61, 32'h62, 32'h63, END_W};
    push_pkt(0);
    model_phase();
    drive();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    en_val = 1'b0;
    pk = '{32'h70, 32'h71, END_W};
    push_pkt(1);
    pc0 = pkt_cnt;
    n = 0;
    while (pkt_cnt == pc0 && n < 40) begin step(); n++; end
    if (pkt_cnt == pc0) fail_now("en_low_pkt_not_done");
    for (int k = 0; k < 6; k++) begin
      step();
      chk("en_low_busy", 64'(busy), 64'd0);
      chk("en_low_src1_valid", 64'(src_valid[1]), 64'd1);
    end
    en_val = 1'b1;
    model_phase();
    run_phase("en_resume_timeout", 100);

    // Randomised traffic with back-pressure, enable gaps and source bubbles.
    rand_ready = 1'b1;
    rand_en = 1'b1;
    bubbles = 1'b1;
    for (int k = 0; k < 30; k++) rand_pkt($urandom_range(0, NS - 1));
    model_phase();
    run_phase("random_timeout", 5000);
    rand_ready = 1'b0;
    rand_en = 1'b0;
    bubbles = 1'b0;

    // Reset mid-packet, then a clean packet from src1.
    pk = '{32'h80, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, END_W};
    push_pkt(0);
    model_phase();
    drive();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    mon_en = 1'b0;
    sys_reset = 1'b1;
    clear_all();
    step();
    sys_reset = 1'b0;
    mptr = 0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_grant", 64'(grant_id), 64'd0);
    chk("mid_rst_pkt_done", 64'(pkt_done), 64'd0);
    mon_en = 1'b1;
    pc0 = pkt_cnt;
    pk = '{32'h90, 32'h91, END_W};
    push_pkt(1);
    model_phase();
    run_phase("post_rst_timeout", 100);
    chk("post_rst_pkt_count", 64'(pkt_cnt - pc0), 64'd1);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_arbiter.md
Name: gpu_cmd_arbiter

Overview:
Packet-granular arbiter that shares the single vertex-processing FIFO input between NUM_SRC instruction streams, such as the host instruction FIFO and a display-list replay engine.
- A packet is one command word, then data words, terminated by the data word GL_END.
- Once a source is granted, it owns the output until its packet terminates, so words from different sources never interleave.
- Sits between the instruction sources and the vertex-processing FIFO, in place of a direct single-source connection.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_W, 32, word width.
- FWD_END, 0: 0 = GL_END consumed and dropped; 1 = GL_END forwarded as the last word.

Ports:
- pll_clock  in  1  sole clock, rising edge.
- sys_reset  in  1  reset; synchronous and active-high.
- arb_enable  in  1  permits new grants; an in-flight packet always completes.
- src_valid  in  NUM_SRC  per-source word valid.
- src_data  in  NUM_SRC*DATA_W  per-source word; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  per-source accept.
- vert_processing_fifo_in_valid  out  1  registered output valid.
- vert_processing_fifo_in_data  out  DATA_W  registered output word.
- vert_processing_fifo_in_ready  in  1  downstream accept.
- grant_id  out  clog2(NUM_SRC)  current/last granted source.
- busy  out  1  high in CMD and DATA states.
- pkt_done  out  1  one-cycle pulse when a packet terminates.

Behaviour:
- Reset (synchronous, sys_reset high at a clock edge):
  - state=IDLE; out valid=0, out data=0; grant_id=0; rr pointer=0; busy=0; pkt_done=0.
  - Any partial packet is abandoned; downstream recovery is not this block's concern.
- Transfer rules:
  - Input transfer: src_valid[i] && src_ready[i].
  - Output transfer: valid && ready.
- Output register:
  - slot_free = !out_valid || vert_processing_fifo_in_ready.
  - src_ready[g] = (state in CMD/DATA) && slot_free && (i == g). All other src_ready bits are 0. src_ready is combinational.
  - An accepted word appears on the output the next cycle (latency 1).
  - Under back-pressure, out valid/data hold stable.
  - When no new word is accepted and the slot frees, out valid drops to 0.
- States:
  - IDLE
    - If arb_enable and any src_valid: pick the first valid source at or after the rr pointer, searching upward and wrapping.
    - Register the pick to grant_id, go to CMD.
    - No word is accepted in IDLE, so there is a 1-cycle gap between packets.
  - CMD
    - On input transfer: forward the word unconditionally (even if it equals GL_END), go to DATA.
  - DATA
    - On input transfer of a word != GL_END: forward it, stay in DATA.
    - On input transfer of GL_END:
      - forward it only if FWD_END=1;
      - pulse pkt_done next cycle;
      - rr pointer = grant_id+1, wrapping to 0 at NUM_SRC;
      - go to IDLE.
- Fairness: round-robin at packet granularity. A source with valid held continuously waits at most NUM_SRC-1 packets.
- arb_enable low in CMD/DATA: no effect. Low in IDLE: stay in IDLE.
- src_valid dropping mid-packet: the grant is held indefinitely; there is no timeout.
- Source i's src_valid is ignored while another source holds the grant.

Decomposition:
- Shared global parameter header holds:
  - GL_END constant (shared with the vertex-processing path);
  - state encodings ARB_IDLE/ARB_CMD/ARB_DATA.
- Natural sub-module: gpu_rr_picker.
  - Combinational round-robin priority select.
  - Inputs: request vector, rr pointer. Outputs: winner index, any-request.

Test Plan:
1. Src0 sends {0x0004, 0x11, 0x22, GL_END}, out_ready=1, FWD_END=0 → output shows 0x0004, 0x11, 0x22 on consecutive cycles, 1-cycle latency; pkt_done pulses once; GL_END is not emitted.
2. Src0 and src1 both valid from reset, each with a 3-word packet → src0 packet fully precedes src1; no interleaving; grant_id 0 then 1; the next contention goes to src0 again.
3. Out_ready held low for 5 cycles mid-packet → out data stable at the pending word; src_ready=0 throughout; no words lost or duplicated after release.
4. Command word = GL_END followed by {0x33, GL_END} → GL_END is forwarded as the command, 0x33 forwarded, the packet ends on the second GL_END.
5. arb_enable dropped in DATA → the current packet completes, then the block stays in IDLE with src1 valid; no grant until arb_enable=1.
6. sys_reset asserted mid-DATA for 1 cycle → next cycle: out valid=0, out data=0, busy=0, grant_id=0; the following packet from src1 is accepted normally.
